// File: rtl/choose_responder.sv
// choose_responder: evaluates a dice roll while the controller is in CHOOSE,
// waits for a debounced confirm press, then pulses done with the outcome.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for active && enable_i
// S_EVAL      | one cycle: score the roll, register result/point/dice_err
// S_WAIT_BTN  | waiting for a qualified press (or active dropping)
// S_RESP      | done pulse; result already holds the outcome
// S_WAIT_EXIT | waiting for active to drop; no further done pulses
module choose_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       enable_i,
    input  logic [3:0] turn,
    input  logic [2:0] die_a,
    input  logic [2:0] die_b,
    input  logic       btn_raw,
    output logic       done,
    output logic [1:0] result,
    output logic [3:0] point,
    output logic       point_valid,
    output logic       dice_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EVAL      = 3'd1;
    localparam logic [2:0] S_WAIT_BTN  = 3'd2;
    localparam logic [2:0] S_RESP      = 3'd3;
    localparam logic [2:0] S_WAIT_EXIT = 3'd4;

    localparam logic [1:0] R_CONT = 2'b00;
    localparam logic [1:0] R_LOST = 2'b01;
    localparam logic [1:0] R_WON  = 2'b10;

    localparam logic [7:0] DEB_LOAD = 8'(DEBOUNCE_CYCLES);

    logic [2:0] state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [7:0] deb_q, deb_d;
    logic [1:0] result_q, result_d;
    logic [3:0] point_q, point_d;
    logic       pv_q, pv_d;
    logic       err_q, err_d;

    logic       press;
    logic       dice_bad;
    logic       first_roll;
    logic       latch_pt;
    logic [3:0] sum;
    logic [1:0] outcome;

    // Score the current roll from the dice, the turn number and the latched point.
    always_comb begin
        sum        = {1'b0, die_a} + {1'b0, die_b};
        dice_bad   = (die_a == 3'd0) || (die_a == 3'd7) ||
                     (die_b == 3'd0) || (die_b == 3'd7);
        first_roll = (turn <= 4'd1);
        outcome    = R_CONT;
        latch_pt   = 1'b0;
        if (!dice_bad) begin
            if (first_roll) begin
                case (sum)
                    4'd7, 4'd11:       outcome = R_WON;
                    4'd2, 4'd3, 4'd12: outcome = R_LOST;
                    default:           latch_pt = 1'b1;
                endcase
            end else if (sum == point_q) begin
                outcome = R_WON;
            end else if (sum == 4'd7) begin
                outcome = R_LOST;
            end
            // A bad roll is never turned into a loss by the turn limit.
            if (outcome == R_CONT && turn == 4'd15) begin
                outcome = R_LOST;
            end
        end
    end

    // Next-state logic: synchronizer always runs; debounce and FSM freeze when enable_i is low.
    always_comb begin
        state_d  = state_q;
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        result_d = result_q;
        point_d  = point_q;
        pv_d     = pv_q;
        err_d    = err_q;
        // Down-counter reaches its terminal count on the DEBOUNCE_CYCLES-th high
        // sample; it then parks at zero so a held button qualifies only once.
        press    = enable_i && sync2_q && (deb_q == 8'd1);
        if (enable_i) begin
            if (!sync2_q) begin
                deb_d = DEB_LOAD;
            end else if (deb_q != 8'd0) begin
                deb_d = deb_q - 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (active) state_d = S_EVAL;
                end
                S_EVAL: begin
                    if (!active) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = outcome;
                        err_d    = dice_bad;
                        if (latch_pt) begin
                            point_d = sum;
                            pv_d    = 1'b1;
                        end
                        state_d = S_WAIT_BTN;
                    end
                end
                S_WAIT_BTN: begin
                    if (!active)    state_d = S_IDLE;
                    else if (press) state_d = S_RESP;
                end
                S_RESP: begin
                    state_d = S_WAIT_EXIT;
                end
                S_WAIT_EXIT: begin
                    if (!active) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            // A finished game (won or lost) forgets its point when the FSM returns to idle.
            if (state_d == S_IDLE && state_q != S_IDLE && result_q != R_CONT) begin
                point_d = 4'd0;
                pv_d    = 1'b0;
            end
        end
    end

    // Registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= DEB_LOAD;
            result_q <= R_CONT;
            point_q  <= 4'd0;
            pv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            result_q <= result_d;
            point_q  <= point_d;
            pv_q     <= pv_d;
            err_q    <= err_d;
        end
    end

    // done marks the cycle RESP actually advances, so a stall never stretches it; reset suppresses it.
    assign done        = (state_q == S_RESP) && enable_i && !rst;
    assign result      = result_q;
    assign point       = point_q;
    assign point_valid = pv_q;
    assign dice_err    = err_q;

endmodule

// File: tb/tb_choose_responder.sv
// tb_choose_responder: directed game scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the responder rules.
module tb_choose_responder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       active = 1'b0;
    logic       enable_i = 1'b0;
    logic [3:0] turn = 4'd1;
    logic [2:0] die_a = 3'd1;
    logic [2:0] die_b = 3'd1;
    logic       btn_raw = 1'b0;
    logic       done;
    logic [1:0] result;
    logic [3:0] point;
    logic       point_valid;
    logic       dice_err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_on = 1'b0;

    choose_responder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .active(active), .enable_i(enable_i),
        .turn(turn), .die_a(die_a), .die_b(die_b), .btn_raw(btn_raw),
        .done(done), .result(result), .point(point),
        .point_valid(point_valid), .dice_err(dice_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules: result code (0 continue, 1 lost, 2 won), whether point latches, dice error.
    function automatic void ref_eval(input int t, input int a, input int b, input int pt,
                                     output int res, output bit latch, output bit bad);
        int s;
        s     = a + b;
        bad   = (a == 0 || a == 7 || b == 0 || b == 7);
        latch = 1'b0;
        res   = 0;
        if (!bad) begin
            if (t <= 1) begin
                if (s == 7 || s == 11)              res = 2;
                else if (s == 2 || s == 3 || s == 12) res = 1;
                else                                latch = 1'b1;
            end else begin
                if (s == pt)      res = 2;
                else if (s == 7)  res = 1;
            end
            if (res == 0 && t == 15) res = 1;
        end
    endfunction

    // Behavioural model: phase of the game plus the run length of high button samples.
    localparam int P_IDLE = 0, P_EVAL = 1, P_WAIT = 2, P_RESP = 3, P_EXIT = 4;
    int m_phase = P_IDLE;
    int m_run = 0;
    bit m_s1 = 0, m_s2 = 0;
    int m_res = 0, m_pt = 0;
    bit m_pv = 0, m_err = 0;

    task automatic go_idle();
        m_phase = P_IDLE;
        if (m_res != 0) begin
            m_pt = 0;
            m_pv = 1'b0;
        end
    endtask

    task automatic model_step();
        int r; bit l, b; bit press;
        if (rst) begin
            m_phase = P_IDLE; m_run = 0; m_s1 = 0; m_s2 = 0;
            m_res = 0; m_pt = 0; m_pv = 0; m_err = 0;
        end else begin
            press = enable_i && m_s2 && (m_run == DEB - 1);
            if (enable_i) begin
                if (!m_s2) m_run = 0;
                else if (m_run < DEB) m_run++;
                case (m_phase)
                    P_IDLE: if (active) m_phase = P_EVAL;
                    P_EVAL: begin
                        if (!active) go_idle();
                        else begin
                            ref_eval(int'(turn), int'(die_a), int'(die_b), m_pt, r, l, b);
                            m_res = r; m_err = b;
                            if (l) begin m_pt = int'(die_a) + int'(die_b); m_pv = 1'b1; end
                            m_phase = P_WAIT;
                        end
                    end
                    P_WAIT: if (!active) go_idle(); else if (press) m_phase = P_RESP;
                    P_RESP: m_phase = P_EXIT;
                    default: if (!active) go_idle();
                endcase
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    always @(posedge clk) model_step();

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("done", int'(done), int'(m_phase == P_RESP && enable_i && !rst));
            chk("result", int'(result), m_res);
            chk("point", int'(point), m_pt);
            chk("point_valid", int'(point_valid), int'(m_pv));
            chk("dice_err", int'(dice_err), int'(m_err));
            if (done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int t, input int a, input int b, input int hold);
        turn = 4'(t); die_a = 3'(a); die_b = 3'(b); active = 1'b1; enable_i = 1'b1;
        repeat (3) cyc();
        btn_raw = 1'b1;
        repeat (hold) cyc();
        btn_raw = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic leave();
        active = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int r; bit l, b; int d0; int btn_left; bit found;

        // Pin the rules model with hand-computed rolls.
        ref_eval(1, 3, 4, 0, r, l, b);  chk("ref_first_7", r, 2);
        ref_eval(1, 1, 1, 0, r, l, b);  chk("ref_first_2", r, 1);
        ref_eval(1, 2, 2, 0, r, l, b);  chk("ref_first_4_latch", int'(l), 1);
        ref_eval(15, 2, 2, 6, r, l, b); chk("ref_turn15", r, 1);
        ref_eval(2, 0, 3, 4, r, l, b);  chk("ref_bad_die", int'(b), 1);

        repeat (3) cyc();
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_point", int'(point), 0);
        chk("rst_pv", int'(point_valid), 0);
        chk("rst_err", int'(dice_err), 0);

        // Natural 7 wins on the first roll.
        d0 = done_cnt;
        play(1, 3, 4, 4);
        chk("win7_done_once", done_cnt - d0, 1);
        chk("win7_result", int'(result), 2);
        chk("win7_pv", int'(point_valid), 0);
        leave();

        // Point 4 set, then made.
        play(1, 2, 2, 4);
        chk("pt4_result", int'(result), 0);
        chk("pt4_point", int'(point), 4);
        chk("pt4_pv", int'(point_valid), 1);
        leave();
        play(2, 1, 3, 4);
        chk("pt4_made", int'(result), 2);
        leave();
        chk("pt4_cleared", int'(point), 0);

        // Point 6 then seven-out; point 6 again then turn limit.
        play(1, 3, 3, 4); leave();
        chk("pt6_point", int'(point), 6);
        play(3, 5, 2, 4);
        chk("seven_out", int'(result), 1);
        leave();
        play(1, 3, 3, 4); leave();
        d0 = done_cnt;
        play(15, 2, 2, 4);
        chk("turn15_forced", int'(result), 1);
        chk("turn15_done", done_cnt - d0, 1);
        leave();

        // Bounce pulses of 3 never qualify; active dropped in WAIT_BTN.
        d0 = done_cnt;
        turn = 4'd1; die_a = 3'd5; die_b = 3'd6; active = 1'b1;
        repeat (3) cyc();
        for (int i = 0; i < 3; i++) begin
            btn_raw = 1'b1; repeat (3) cyc();
            btn_raw = 1'b0; repeat (1) cyc();
        end
        repeat (4) cyc();
        chk("bounce_no_done", done_cnt - d0, 0);
        leave();
        chk("drop_no_done", done_cnt - d0, 0);

        // Illegal die keeps the point.
        play(1, 4, 4, 4); leave();
        play(2, 0, 3, 4);
        chk("bad_result", int'(result), 0);
        chk("bad_err", int'(dice_err), 1);
        chk("bad_point", int'(point), 8);
        leave();

        // Reset in the RESP cycle.
        turn = 4'd2; die_a = 3'd4; die_b = 3'd4; active = 1'b1;
        repeat (3) cyc();
        btn_raw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (done) found = 1'b1;
        end
        chk("resp_reached", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("rst_resp_done", int'(done), 0);
        cyc();
        rst = 1'b0;
        btn_raw = 1'b0;
        #1;
        chk("rst2_done", int'(done), 0);
        chk("rst2_result", int'(result), 0);
        chk("rst2_point", int'(point), 0);
        chk("rst2_pv", int'(point_valid), 0);
        chk("rst2_err", int'(dice_err), 0);
        active = 1'b0;
        repeat (3) cyc();

        // Randomized traffic.
        btn_left = 0;
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            enable_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) active = ~active;
            if (btn_left == 0) begin
                btn_raw  = ~btn_raw;
                btn_left = $urandom_range(1, 7);
            end else begin
                btn_left--;
            end
            if ($urandom_range(0, 7) == 0) begin
                die_a = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
                die_b = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 7) == 0) turn = 4'($urandom_range(0, 15));
            cyc();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
